muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer beside the EX-stage ALU.
- Accepts an operation from the EX stage and runs an iterative shift-add multiply or restoring divide over one 32-bit operand pair.
- Holds the HI/LO result registers.
- Drives a stall request that freezes the ID/EXE pipeline register while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  operation request from EX stage, sampled on rising clk.
- op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
- sgn  input  1  signed-operation select; used only with SIGNED_MD_EN.
- a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when HI/LO hold a new mul/div result.
- stall  output  1  pipeline stall request.
- div0  output  1  sticky divide-by-zero flag of the last DIVU; cleared by the next accepted mul/div.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: clk and reset only, as stated above (one clock; asynchronous active-high rst).
- Reset values: state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter=0. Stall is then 0 whenever start=0.
- States: IDLE, MUL, DIV, FIX (only with SIGNED_MD_EN), DONE.
- IDLE, start=1, op=MTHI: hi<=a at the edge; no busy, no done.
- IDLE, start=1, op=MTLO: lo<=a at the edge; no busy, no done.
- IDLE, start=1, op=MULTU:
  - latch a and b; clear product accumulator; counter<=0; go to MUL.
  - each MUL cycle: if multiplier LSB is 1, add multiplicand into upper half; shift the 2*WIDTH accumulator right by 1, with the carry entering the MSB.
  - after WIDTH iterations go to DONE.
- IDLE, start=1, op=DIVU, b!=0:
  - remainder<=0, quotient<=a; go to DIV.
  - each DIV cycle: shift {rem,quot} left by 1; trial-subtract b; if no borrow keep the difference and set quotient LSB to 1.
  - after WIDTH iterations go to DONE.
- DIVU with b==0: skip iteration; next cycle DONE with hi=a, lo=all-ones, div0=1.
- Latency: start accepted at edge T.
  - busy=1 in cycles T+1 .. T+WIDTH.
  - DONE in cycle T+WIDTH+1: done=1, busy=0.
  - hi/lo updated at the edge entering DONE.
  - DONE returns to IDLE unconditionally.
  - Divide-by-zero: DONE at T+1.
- Results: MULTU gives {hi,lo} = a*b (full 2*WIDTH product). DIVU gives lo = quotient, hi = remainder.
- hi/lo are not modified during iteration; they hold old values until the DONE edge.
- stall = busy | (state==IDLE & start & ~op[1]), combinational.
  - The stall deasserts in the DONE cycle, so the stalled instruction proceeds with the result visible.
- start is ignored in MUL, DIV, FIX and DONE, including MTHI/MTLO; the EX stage is frozen by stall.
- MTHI/MTLO issued in the same cycle as DONE is dropped. The pipeline guarantees this cannot occur.
- rst mid-operation: immediate return to IDLE; hi/lo cleared; no done pulse; partial result discarded.
- Counter wraps never: compare counter == WIDTH-1 on the last iteration.

Optional Feature:
- Macro: SIGNED_MD_EN.
- Defined: sgn=1 with MULTU/DIVU selects signed MULT/DIV.
  - Operands are converted to magnitudes at acceptance.
  - After the last iteration, the extra FIX state negates the results: product if signs differ; quotient if signs differ; remainder if the dividend is negative.
  - done at T+WIDTH+2. Signed divide-by-zero behaves as the unsigned case.
- Undefined: sgn is ignored; all operations are unsigned; no FIX state.

Test Plan:
- MULTU a=7, b=6 -> stall=1 in the start cycle; busy for 32 cycles; done at T+33 with hi=0x00000000, lo=0x0000002A.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, div0=0.
- DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002 at done. Then DIVU a=5, b=0 -> done at T+1, hi=0x00000005, lo=0xFFFFFFFF, div0=1.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 in consecutive cycles -> hi/lo updated one edge each; stall=0, done=0 throughout.
- Start MULTU 3*4, assert rst at iteration 10 -> busy=0, hi=lo=0, no done pulse. A new MULTU 3*4 afterwards gives lo=12.
- SIGNED_MD_EN, sgn=1, DIVU a=0xFFFFFFF9 (-7), b=2 -> done at T+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Without the macro -> unsigned result lo=0x7FFFFFFC, hi=0x00000001.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer with HI/LO result registers.
// MULTU runs a WIDTH-step shift-add multiply and DIVU a WIDTH-step restoring
// divide. MTHI/MTLO write HI/LO directly. stall freezes the ID/EXE register
// while an operation is in flight.
// Optional macro SIGNED_MD_EN: when defined, sgn=1 selects signed MULT/DIV.
// Operands are converted to magnitudes, and an extra FIX state fixes the signs.
module muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
`ifdef SIGNED_MD_EN
      S_FIX  = 3'd3,
`endif
      S_DONE = 3'd4
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   // MUL: {partial product upper half, remaining multiplier bits}
   // DIV: {remainder, quotient/dividend bits}
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   step_next;
   logic [WIDTH-1:0]     a_in;
   logic [WIDTH-1:0]     b_in;

`ifdef SIGNED_MD_EN
   logic                 fix_en;    // operation is signed and needs FIX
   logic                 fix_mul;   // FIX applies to a product
   logic                 neg_q;     // product/quotient negative
   logic                 neg_r;     // remainder negative
   logic [2*WIDTH-1:0]   fix_prod;
   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;
`else
   logic                 unused_sgn;
   assign unused_sgn = sgn;
`endif

   // Stall the EX stage while iterating and in the cycle a mul/div is issued
   assign stall = busy | ((state == S_IDLE) & start & ~op[1]);

   // Operand conditioning: magnitudes for signed operations, raw otherwise
   always_comb begin
      a_in = a;
      b_in = b;
`ifdef SIGNED_MD_EN
      a_in = (sgn && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
      b_in = (sgn && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
`endif
   end

   // One iteration of shift-add multiply and restoring divide
   always_comb begin
      if (acc[0]) begin
         mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      end else begin
         mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
      end
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd};
      if (!div_diff[WIDTH]) begin
         div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
      if (state == S_MUL) begin
         step_next = mul_next;
      end else begin
         step_next = div_next;
      end
   end

`ifdef SIGNED_MD_EN
   // Sign correction of the magnitude result
   always_comb begin
      fix_prod = neg_q ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
      if (fix_mul) begin
         fix_hi = fix_prod[2*WIDTH-1:WIDTH];
         fix_lo = fix_prod[WIDTH-1:0];
      end else begin
         fix_hi = neg_r ? (~acc[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                        : acc[2*WIDTH-1:WIDTH];
         fix_lo = neg_q ? (~acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                        : acc[WIDTH-1:0];
      end
   end
`endif

   // Sequencer FSM with HI/LO, busy, done and div0 registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         acc   <= '0;
         opnd  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         div0  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
`ifdef SIGNED_MD_EN
         fix_en  <= 1'b0;
         fix_mul <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
`ifdef SIGNED_MD_EN
                  fix_en  <= sgn;
                  fix_mul <= (op == OP_MULTU);
                  neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r   <= sgn & a[WIDTH-1];
`endif
                  case (op)
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     OP_MULTU: begin
                        acc   <= {{WIDTH{1'b0}}, b_in};
                        opnd  <= a_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        div0  <= 1'b0;
                        state <= S_MUL;
                     end
                     OP_DIVU: begin
                        if (b == '0) begin
                           hi    <= a;
                           lo    <= {WIDTH{1'b1}};
                           div0  <= 1'b1;
                           done  <= 1'b1;
                           state <= S_DONE;
                        end else begin
                           acc   <= {{WIDTH{1'b0}}, a_in};
                           opnd  <= b_in;
                           cnt   <= '0;
                           busy  <= 1'b1;
                           div0  <= 1'b0;
                           state <= S_DIV;
                        end
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               acc <= step_next;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
`ifdef SIGNED_MD_EN
                  if (fix_en) begin
                     state <= S_FIX;
                  end else begin
                     hi    <= step_next[2*WIDTH-1:WIDTH];
                     lo    <= step_next[WIDTH-1:0];
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
`else
                  hi    <= step_next[2*WIDTH-1:WIDTH];
                  lo    <= step_next[WIDTH-1:0];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
`endif
               end
            end
`ifdef SIGNED_MD_EN
            S_FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end
`endif
            S_DONE: state <= S_IDLE;
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the stimulus pushes hand-computed results,
// and a monitor pops and checks them on every done pulse.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic        sgn;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        stall;
   logic        div0;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        div0;
      int          done_cyc;
      int          busy_n;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   int   done_seen = 0;

   muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
      .busy(busy), .done(done), .stall(stall), .div0(div0), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency checks
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: count busy cycles and check every done pulse against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               done_seen++;
               if (sbq.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
               end else begin
                  e = sbq.pop_front();
                  check("hi", hi, e.hi);
                  check("lo", lo, e.lo);
                  check("div0", div0, e.div0);
                  check("done_cycle", cyc, e.done_cyc);
                  check("busy_cycles", busy_cnt, e.busy_n);
                  check("busy_in_done", busy, 1'b0);
                  check("stall_in_done", stall, 1'b0);
               end
               busy_cnt = 0;
            end
         end
      end
   end

   task automatic drain();
      int n = 0;
      #1;
      while (sbq.size() != 0 && n < 80) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sbq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: got no done after %0d cycles expected done", n);
         sbq.delete();
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic s, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int lat);
      exp_t e;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv; sgn = s;
      e.hi = eh; e.lo = el; e.div0 = ed; e.done_cyc = cyc + lat; e.busy_n = lat - 1;
      sbq.push_back(e);
      #1 check("stall_start", stall, 1'b1);
      @(negedge clk);
      start = 1'b0; sgn = 1'b0;
      drain();
   endtask

   // Watchdog so the bench can never hang
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      int d0;
      rst = 1'b1; start = 1'b0; op = 2'b00; sgn = 1'b0; a = 32'h0; b = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_div0", div0, 1'b0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);

      // MTHI then MTLO back to back: one edge each, never stall or done
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 32'h12345678;
      #1 check("mthi_stall", stall, 1'b0);
      @(negedge clk);
      check("mthi_hi", hi, 32'h12345678);
      check("mthi_done", done, 1'b0);
      op = 2'b11; a = 32'h9ABCDEF0;
      #1 check("mtlo_stall", stall, 1'b0);
      @(negedge clk);
      check("mtlo_lo", lo, 32'h9ABCDEF0);
      check("mtlo_hi", hi, 32'h12345678);
      check("mtlo_done", done, 1'b0);
      start = 1'b0;

      run_op(2'b00, 32'd7, 32'd6, 1'b0, 32'h0, 32'h0000002A, 1'b0, 33);
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
      run_op(2'b01, 32'd100, 32'd7, 1'b0, 32'h00000002, 32'h0000000E, 1'b0, 33);

      // start is ignored while busy; hi/lo hold their old values during iteration
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
      e.hi = 32'h0; e.lo = 32'd6; e.div0 = 1'b0; e.done_cyc = cyc + 33; e.busy_n = 32;
      sbq.push_back(e);
      @(negedge clk);
      op = 2'b10; a = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("busy_hold_hi", hi, 32'h00000002);
         check("busy_hold_lo", lo, 32'h0000000E);
         check("busy_stall", stall, 1'b1);
      end
      start = 1'b0;
      drain();

      run_op(2'b01, 32'd5, 32'd0, 1'b0, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1);
      // div0 is sticky across MTLO
      @(negedge clk);
      start = 1'b1; op = 2'b11; a = 32'h00000055;
      @(negedge clk);
      start = 1'b0;
      check("div0_sticky", div0, 1'b1);
      check("mtlo2_lo", lo, 32'h00000055);
      run_op(2'b01, 32'd3, 32'd10, 1'b0, 32'h00000003, 32'h00000000, 1'b0, 33);
      run_op(2'b01, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33);

      // Reset in the middle of a multiply: no done, hi/lo cleared
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_hi", hi, 32'h0);
      check("midrst_lo", lo, 32'h0);
      check("midrst_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      d0 = done_seen;
      repeat (40) @(negedge clk);
      check("midrst_no_done", done_seen, d0);
      run_op(2'b00, 32'd3, 32'd4, 1'b0, 32'h0, 32'd12, 1'b0, 33);

`ifdef SIGNED_MD_EN
      run_op(2'b01, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
      run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34);
`else
      run_op(2'b01, 32'hFFFFFFF9, 32'd2, 1'b1, 32'h00000001, 32'h7FFFFFFC, 1'b0, 33);
      run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1, 32'h00000004, 32'hFFFFFFF1, 1'b0, 33);
`endif

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
